// File: rtl/project_primitive.sv
// project_primitive: transforms each vertex of one primitive by an MVP matrix, clip-tests it,
// divides by w, maps it to the framebuffer viewport and optionally back-face culls the triangle.
module project_primitive #(
    parameter int unsigned COORD_WIDTH     = 32,
    parameter int unsigned FRAC_BITS       = 16,
    parameter int unsigned NUM_VERTS       = 3,
    parameter int unsigned DEPTH_BIT_WIDTH = 16,
    parameter int unsigned FB_WIDTH        = 320,
    parameter int unsigned FB_HEIGHT       = 180
) (
    input  logic                                          clk_in,
    input  logic                                          rst_n_in,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [NUM_VERTS-1:0][2:0][COORD_WIDTH-1:0]    verts_in,
    input  logic [3:0][3:0][COORD_WIDTH-1:0]              mvp_matrix,
    input  logic [1:0]                                    cull_mode,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_VERTS-1:0][2:0][COORD_WIDTH-1:0]    screen_verts,
    output logic [NUM_VERTS-1:0][DEPTH_BIT_WIDTH-1:0]     depth,
    output logic [1:0]                                    status,
    output logic                                          busy
);

    localparam int unsigned W   = COORD_WIDTH;
    localparam int unsigned W2  = 2 * COORD_WIDTH;
    localparam int unsigned F   = FRAC_BITS;
    localparam int unsigned IW  = COORD_WIDTH - FRAC_BITS;
    localparam int unsigned AW  = 2 * (COORD_WIDTH - FRAC_BITS) + 2;
    localparam int unsigned DSH = FRAC_BITS + 1 - DEPTH_BIT_WIDTH;

    localparam logic [W-1:0]         OneC    = W'(1) << F;
    localparam logic signed [W2-1:0] OneW    = W2'(1) << F;
    localparam logic signed [W2-1:0] HalfW   = W2'(FB_WIDTH / 2);
    localparam logic signed [W2-1:0] HalfH   = W2'(FB_HEIGHT / 2);
    localparam logic signed [W2-1:0] DMax    = (W2'(1) << DEPTH_BIT_WIDTH) - W2'(1);
    localparam logic [1:0]           LastIdx = 2'(NUM_VERTS - 1);

    typedef enum logic [2:0] {
        StIdle, StXform, StClip, StDivide, StViewport, StNext, StCull, StOut
    } state_e;

    state_e                                    state_q, state_d;
    logic [1:0]                                vidx_q, vidx_d;
    logic [NUM_VERTS-1:0][2:0][W-1:0]          verts_q, verts_d;
    logic [3:0][3:0][W-1:0]                    mvp_q, mvp_d;
    logic [1:0]                                cull_q, cull_d;
    logic [3:0][W-1:0]                         clip_q, clip_d;
    logic [2:0][W-1:0]                         ndc_q, ndc_d;
    logic [NUM_VERTS-1:0][2:0][W-1:0]          screen_q, screen_d;
    logic [NUM_VERTS-1:0][DEPTH_BIT_WIDTH-1:0] depth_q, depth_d;
    logic [1:0]                                status_q, status_d;

    function automatic logic signed [W2-1:0] sext(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    // Integer part of a screen coordinate, sign-extended to the area width
    function automatic logic signed [AW-1:0] ipart(input logic [W-1:0] v);
        return {{(AW - IW){v[W-1]}}, v[W-1:F]};
    endfunction

    // Fixed-point matrix-vector product for the current vertex (w = ONE)
    logic [3:0][W-1:0] vin;
    logic [3:0][W-1:0] xf;
    always_comb begin : p_xform
        logic signed [W2-1:0] acc;
        vin = {OneC, verts_q[vidx_q]};
        xf  = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int c = 0; c < 4; c++) begin
                acc = acc + sext(mvp_q[r][c]) * sext(vin[c]);
            end
            xf[r] = W'(acc >>> F);
        end
    end

    // Clip-space rejection test against the w-bounded cube
    logic signed [W2-1:0] cx, cy, cz, cw;
    logic                 reject;
    assign cx = sext(clip_q[0]);
    assign cy = sext(clip_q[1]);
    assign cz = sext(clip_q[2]);
    assign cw = sext(clip_q[3]);
    assign reject = (cw <= 0) || (cx > cw) || (-cx > cw) || (cy > cw) || (-cy > cw)
                    || (cz > cw) || (-cz > cw);

    // Three parallel fixed-point dividers for the perspective divide
    logic [2:0][W-1:0] quot;
    logic              div_ok;
    always_comb begin : p_divide
        logic signed [W2-1:0] q;
        quot   = '0;
        div_ok = (cw != 0);
        for (int i = 0; i < 3; i++) begin
            if (cw != 0) q = (sext(clip_q[i]) <<< F) / cw;
            else         q = '0;
            // Quotient must fit back into the coordinate width
            if (q[W2-1:W-1] != {(W + 1){q[W-1]}}) div_ok = 1'b0;
            quot[i] = W'(q);
        end
    end

    // Viewport mapping and depth quantisation of the current NDC vertex
    logic [W-1:0]               vp_sx, vp_sy;
    logic [DEPTH_BIT_WIDTH-1:0] vp_depth;
    always_comb begin : p_viewport
        logic signed [W2-1:0] zs;
        vp_sx    = W'((sext(ndc_q[0]) + OneW) * HalfW);
        vp_sy    = W'((OneW - sext(ndc_q[1])) * HalfH);
        zs       = (sext(ndc_q[2]) + OneW) >>> DSH;
        vp_depth = (zs > DMax) ? DEPTH_BIT_WIDTH'(DMax) : DEPTH_BIT_WIDTH'(zs);
    end

    // Signed screen-space area decides culling; only triangles are culled
    logic cull_hit;
    if (NUM_VERTS == 3) begin : g_cull
        logic signed [AW-1:0] x0, y0, x1, y1, x2, y2, area;
        assign x0   = ipart(screen_q[0][0]);
        assign y0   = ipart(screen_q[0][1]);
        assign x1   = ipart(screen_q[1][0]);
        assign y1   = ipart(screen_q[1][1]);
        assign x2   = ipart(screen_q[2][0]);
        assign y2   = ipart(screen_q[2][1]);
        assign area = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
        assign cull_hit = ((cull_q == 2'd1) && (area <= 0)) ||
                          ((cull_q == 2'd2) && (area >= 0));
    end else begin : g_nocull
        assign cull_hit = 1'b0;
    end

    // Next-state logic for the control FSM and its captured datapath values
    always_comb begin
        state_d  = state_q;
        vidx_d   = vidx_q;
        verts_d  = verts_q;
        mvp_d    = mvp_q;
        cull_d   = cull_q;
        clip_d   = clip_q;
        ndc_d    = ndc_q;
        screen_d = screen_q;
        depth_d  = depth_q;
        status_d = status_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    verts_d  = verts_in;
                    mvp_d    = mvp_matrix;
                    cull_d   = cull_mode;
                    screen_d = '0;
                    depth_d  = '0;
                    status_d = 2'd0;
                    vidx_d   = 2'd0;
                    state_d  = StXform;
                end
            end
            StXform: begin
                clip_d  = xf;
                state_d = StClip;
            end
            StClip: begin
                if (reject) begin
                    status_d = 2'd1;
                    state_d  = StOut;
                end else begin
                    state_d = StDivide;
                end
            end
            StDivide: begin
                if (!div_ok) begin
                    status_d = 2'd2;
                    state_d  = StOut;
                end else begin
                    ndc_d   = quot;
                    state_d = StViewport;
                end
            end
            StViewport: begin
                screen_d[vidx_q] = {ndc_q[2], vp_sy, vp_sx};
                depth_d[vidx_q]  = vp_depth;
                state_d          = StNext;
            end
            StNext: begin
                if (vidx_q == LastIdx) begin
                    state_d = StCull;
                end else begin
                    vidx_d  = vidx_q + 2'd1;
                    state_d = StXform;
                end
            end
            StCull: begin
                status_d = cull_hit ? 2'd3 : 2'd0;
                state_d  = StOut;
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= StIdle;
            vidx_q   <= 2'd0;
            verts_q  <= '0;
            mvp_q    <= '0;
            cull_q   <= 2'd0;
            clip_q   <= '0;
            ndc_q    <= '0;
            screen_q <= '0;
            depth_q  <= '0;
            status_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            vidx_q   <= vidx_d;
            verts_q  <= verts_d;
            mvp_q    <= mvp_d;
            cull_q   <= cull_d;
            clip_q   <= clip_d;
            ndc_q    <= ndc_d;
            screen_q <= screen_d;
            depth_q  <= depth_d;
            status_q <= status_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StOut);
    assign busy         = (state_q != StIdle);
    assign screen_verts = screen_q;
    assign depth        = depth_q;
    assign status       = status_q;

endmodule
